// File: rtl/led_breathe_pwm.sv
// rtl/led_breathe_pwm.sv - breathing LED PWM driver with tick-stepped duty ramp
module led_breathe_pwm #(
   parameter int WIDTH      = 8,
   parameter int STEP_TICKS = 1,
   parameter int HOLD_STEPS = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             tick,
   output logic             pwm_o,
   output logic [WIDTH-1:0] duty,
   output logic [1:0]       state_o,
   output logic             cycle_done
);

   typedef enum logic [1:0] {
      RISE      = 2'd0,
      HOLD_HIGH = 2'd1,
      FALL      = 2'd2,
      HOLD_LOW  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
   localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

   logic [WIDTH-1:0] pwm_count;
   logic [WIDTH-1:0] duty_active;
   logic [TW-1:0]    tick_count;
   logic [HW-1:0]    hold_count;
   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] duty_next;
   logic [WIDTH-1:0] duty_inc;
   logic [WIDTH-1:0] duty_dec;
   logic [HW-1:0]    hold_next;
   logic             done_next;
   logic             step;

   assign state_o  = state;
   assign duty_inc = duty + 1'b1;
   assign duty_dec = duty - 1'b1;

   // A step fires on the tick that completes a group of STEP_TICKS ticks
   always_comb begin
      step = enable & tick & (tick_count == TICK_LAST);
   end

   // Free-running PWM counter; duty shadow only reloads at period end so a period never changes mid-way
   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_count   <= '0;
         duty_active <= '0;
         pwm_o       <= 1'b0;
      end else if (enable) begin
         pwm_count <= pwm_count + 1'b1;
         if (pwm_count == MAX) begin
            duty_active <= duty;
         end
         pwm_o <= (pwm_count < duty_active);
      end else begin
         pwm_o <= 1'b0;
      end
   end

   // Tick prescaler: counts ticks and wraps on the step tick
   always_ff @(posedge clock) begin
      if (reset) begin
         tick_count <= '0;
      end else if (enable && tick) begin
         if (tick_count == TICK_LAST) begin
            tick_count <= '0;
         end else begin
            tick_count <= tick_count + 1'b1;
         end
      end
   end

   // Ramp state register; with enable low step never fires so everything holds
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= RISE;
         duty       <= '0;
         hold_count <= '0;
         cycle_done <= 1'b0;
      end else begin
         state      <= state_next;
         duty       <= duty_next;
         hold_count <= hold_next;
         cycle_done <= done_next;
      end
   end

   // Ramp next-state: duty saturates at the ends so it can never wrap
   always_comb begin
      state_next = state;
      duty_next  = duty;
      hold_next  = hold_count;
      done_next  = 1'b0;
      if (step) begin
         case (state)
            RISE: begin
               if (duty == MAX) begin
                  state_next = HOLD_HIGH;
               end else begin
                  duty_next = duty_inc;
                  if (duty_inc == MAX) begin
                     state_next = HOLD_HIGH;
                  end
               end
            end
            HOLD_HIGH: begin
               if (hold_count == HOLD_LAST) begin
                  hold_next  = '0;
                  state_next = FALL;
               end else begin
                  hold_next = hold_count + 1'b1;
               end
            end
            FALL: begin
               if (duty == '0) begin
                  state_next = HOLD_LOW;
               end else begin
                  duty_next = duty_dec;
                  if (duty_dec == '0) begin
                     state_next = HOLD_LOW;
                  end
               end
            end
            HOLD_LOW: begin
               if (hold_count == HOLD_LAST) begin
                  hold_next  = '0;
                  state_next = RISE;
                  done_next  = 1'b1;
               end else begin
                  hold_next = hold_count + 1'b1;
               end
            end
            default: begin
               state_next = RISE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_breathe_pwm.sv
// tb/tb_led_breathe_pwm.sv - directed self-checking bench for led_breathe_pwm
module tb_led_breathe_pwm;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       tick;
   logic       tick_b;
   logic       pwm_o;
   logic       pwm_o_b;
   logic [3:0] duty;
   logic [3:0] duty_b;
   logic [1:0] state_o;
   logic [1:0] state_o_b;
   logic       cycle_done;
   logic       cycle_done_b;

   int n_checks = 0;
   int n_fail   = 0;
   int n        = 0;

   always #5 clock = ~clock;

   led_breathe_pwm #(.WIDTH(4), .STEP_TICKS(1), .HOLD_STEPS(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .tick       (tick),
      .pwm_o      (pwm_o),
      .duty       (duty),
      .state_o    (state_o),
      .cycle_done (cycle_done)
   );

   led_breathe_pwm #(.WIDTH(4), .STEP_TICKS(3), .HOLD_STEPS(2)) dut_b (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .tick       (tick_b),
      .pwm_o      (pwm_o_b),
      .duty       (duty_b),
      .state_o    (state_o_b),
      .cycle_done (cycle_done_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, n, obs, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clock);
      #1;
      n++;
   endtask

   function automatic int exp_duty(input int e);
      if (e <= 15) return e;
      if (e <= 17) return 15;
      if (e <= 31) return 32 - e;
      return 0;
   endfunction

   function automatic int exp_state(input int e);
      if (e <= 14) return 0;
      if (e <= 16) return 1;
      if (e <= 31) return 2;
      if (e <= 33) return 3;
      return 0;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int done_cnt;
      int highs;
      int highs2;
      logic exp_pwm;

      reset  = 1'b1;
      enable = 1'b0;
      tick   = 1'b0;
      tick_b = 1'b0;
      edge_step();
      edge_step();
      chk("reset_duty", duty, 0);
      chk("reset_state", state_o, 0);
      chk("reset_pwm", pwm_o, 0);
      chk("reset_done", cycle_done, 0);

      // full breathe cycles with a tick every clock
      reset    = 1'b0;
      enable   = 1'b1;
      tick     = 1'b1;
      n        = 0;
      done_cnt = 0;
      for (int i = 1; i <= 68; i++) begin
         edge_step();
         e = ((n - 1) % 34) + 1;
         chk("ramp_duty", duty, exp_duty(e));
         chk("ramp_state", state_o, exp_state(e));
         chk("ramp_done", cycle_done, (e == 34) ? 1 : 0);
         if (cycle_done) done_cnt++;
      end
      chk("done_count", done_cnt, 2);

      // ramp to duty 5 then stop ticking
      for (int i = 0; i < 5; i++) edge_step();
      chk("duty5", duty, 5);
      tick = 1'b0;
      while (n < 80) begin
         edge_step();
         chk("duty5_hold", duty, 5);
      end
      highs = 0;
      for (int i = 0; i < 32; i++) begin
         edge_step();
         exp_pwm = (((n - 1) % 16) < 5);
         chk("pwm5", pwm_o, exp_pwm);
         if (pwm_o) highs++;
      end
      chk("pwm5_highs", highs, 10);

      // step coincident with period wrap: 7 then 8
      while (n < 125) edge_step();
      tick = 1'b1;
      edge_step();
      edge_step();
      chk("duty7", duty, 7);
      edge_step();
      chk("duty8", duty, 8);
      tick   = 1'b0;
      highs  = 0;
      highs2 = 0;
      for (int i = 0; i < 32; i++) begin
         edge_step();
         exp_pwm = (((n - 1) % 16) < ((n <= 144) ? 7 : 8));
         chk("pwm_wrap", pwm_o, exp_pwm);
         if (pwm_o) begin
            if (n <= 144) highs++;
            else highs2++;
         end
      end
      chk("wrap_highs_7", highs, 7);
      chk("wrap_highs_8", highs2, 8);

      // freeze mid-RISE at duty 9
      tick = 1'b1;
      edge_step();
      chk("duty9", duty, 9);
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick = i[0];
         edge_step();
         chk("frz_pwm", pwm_o, 0);
         chk("frz_duty", duty, 9);
         chk("frz_state", state_o, 0);
         chk("frz_done", cycle_done, 0);
      end
      enable = 1'b1;
      tick   = 1'b1;
      edge_step();
      chk("resume_duty", duty, 10);
      chk("resume_pwm", pwm_o, 1);

      // run into FALL at duty 3, then reset
      for (int i = 0; i < 19; i++) edge_step();
      chk("fall_duty3", duty, 3);
      chk("fall_state", state_o, 2);
      reset = 1'b1;
      edge_step();
      chk("rst_duty", duty, 0);
      chk("rst_state", state_o, 0);
      chk("rst_pwm", pwm_o, 0);
      chk("rst_done", cycle_done, 0);
      chk("rst_duty_b", duty_b, 0);
      reset = 1'b0;
      tick  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         edge_step();
         chk("post_rst_done", cycle_done, 0);
         chk("post_rst_duty", duty, 0);
      end

      // STEP_TICKS=3 instance, tick every 4th clock
      for (int m = 1; m <= 48; m++) begin
         tick_b = ((m % 4) == 0);
         edge_step();
         chk("st3_duty", duty_b, m / 12);
         chk("st3_tickcnt", dut_b.tick_count, (m / 4) % 3);
      end
      tick_b = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_breathe_pwm.md
Name: led_breathe_pwm

Overview:
- Downstream LED driver stage: consumes a periodic single-cycle tick strobe from the shared counter (its tc output) and produces a PWM LED drive whose duty ramps up, holds, ramps down and holds ("breathing").
- Replaces the plain toggle register wherever a fading indicator is wanted.
- Contains a free-running PWM counter, a glitch-free duty shadow register and a four-state ramp state machine.

Parameters:
- WIDTH, 8: PWM/duty resolution in bits. MAX = 2^WIDTH-1. Legal range 2..16.
- STEP_TICKS, 1: tick strobes per ramp step. Must be >= 1.
- HOLD_STEPS, 4: ramp steps spent in each hold state. Must be >= 1.

Ports:
- clock, input, 1: single system clock, all logic rising-edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: run control. Low freezes all state and forces the LED off.
- tick, input, 1: one-cycle step strobe, e.g. counter tc.
- pwm_o, input→output, 1: registered LED drive.
- duty, output, WIDTH: current ramp duty (working value).
- state_o, output, 2: ramp state encoding: RISE=0, HOLD_HIGH=1, FALL=2, HOLD_LOW=3.
- cycle_done, output, 1: one-cycle pulse at the end of each full breathe cycle.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values (next edge with reset=1, overrides everything): pwm_count=0, duty=0, duty_active=0, tick_count=0, hold_count=0, state=RISE, pwm_o=0, cycle_done=0.

PWM path (only while enable=1):
- pwm_count increments every clock and wraps from MAX to 0.
- At the edge where pwm_count==MAX, duty_active loads the *pre-edge* duty value. This is the only load point, so no mid-period glitches.
- pwm_o <= (pwm_count < duty_active). This is registered, one cycle of latency.
- duty_active=0 gives pwm_o constant 0.
- duty_active=MAX gives MAX high cycles out of every 2^WIDTH (never 100%).

Step generation (only while enable=1):
- On tick=1, tick_count increments.
- If tick_count==STEP_TICKS-1, tick_count<=0 and a step event occurs in that same edge.
- With tick=0, tick_count holds.

State machine (advances only on step events):
- RISE: duty<=duty+1. If duty+1==MAX, go to HOLD_HIGH.
- HOLD_HIGH: hold_count+1. When hold_count==HOLD_STEPS-1, hold_count<=0 and go to FALL.
- FALL: duty<=duty-1. If duty-1==0, go to HOLD_LOW.
- HOLD_LOW: hold_count+1. When hold_count==HOLD_STEPS-1, hold_count<=0, go to RISE, and cycle_done=1 for exactly that one cycle.
- duty never over- or underflows. Arithmetic is WIDTH-bit unsigned.
- Full cycle length: 2*MAX + 2*HOLD_STEPS step events.

Simultaneous and boundary cases:
- Step event and PWM wrap in the same edge: duty_active gets the old duty; the new duty takes effect one PWM period later.
- enable=0: pwm_count, duty, duty_active, tick_count, hold_count and state all hold. tick is ignored (not queued). pwm_o<=0 on the next edge. cycle_done<=0.
- On re-enable, resume from the frozen state. pwm_o follows the compare rule from the next edge.
- reset asserted mid-ramp or mid-hold: full return to reset values on that edge. reset has priority over enable and tick.
- tick held high continuously: treated as one tick per clock.

Test Plan:
- WIDTH=4, STEP_TICKS=1, HOLD_STEPS=2, enable=1, tick every clock → duty 0,1,…,15; 2 hold steps; 14,…,0; 2 hold steps. cycle_done pulses once per 34 ticks; state_o follows 0→1→2→3→0.
- WIDTH=4, tick held low, duty forced to 5 via ramp then ticks stopped → pwm_o high exactly 5 of every 16 cycles. High window starts 1 cycle after pwm_count=0.
- Step event on the same edge as pwm_count==15 while duty=7→8 → next period shows 7 high cycles, the following period 8. No partial-period change.
- STEP_TICKS=3, tick every 4th clock → duty increments once per 3 ticks (every 12 clocks). tick_count returns to 0 each step.
- Mid-RISE at duty=9: deassert enable for 20 cycles while tick pulses → pwm_o=0 throughout, duty stays 9, state unchanged. On re-enable, duty resumes 9→10 after 1 step.
- In FALL at duty=3: assert reset one cycle → next cycle duty=0, state_o=0, pwm_o=0, cycle_done=0. No spurious cycle_done pulse.
